pid_state_sampler: RTL
======================

// Module: pid_state_sampler
// PURPOSE
//  Feed side of the float PID controller: periodically samples integer encoder position/displacement,
//  forms the selected control quantity (position, velocity, displacement) and converts it to IEEE-754 single.
//  Presents it as the controller's 'state' input with a one-cycle update_controller strobe.
//  Sits between the encoder/spring-sensor decoders and PID_controller, one instance per motor.
// PARAMETERS
//  SAMPLE_PERIOD  50000  clock cycles between automatic samples (1 kHz @ 50 MHz); must be >= 40
// PORTS
//  clock             in   1   system clock
//  reset             in   1   synchronous, active-high reset
//  enable            in   1   1: periodic sampling runs; 0: tick counter held at 0, no automatic samples
//  sample_req        in   1   one-cycle request for an immediate sample (accepted even when enable=0)
//  control_mode      in   2   0 position, 1 velocity, 2 displacement, 3 reserved (state forced to +0.0)
//  position          in   32  signed encoder position, two's complement
//  displacement      in   32  signed spring displacement, two's complement
//  state             out  32  IEEE-754 single, registered; holds last result
//  update_controller out  1   one-cycle pulse, same cycle 'state' takes its new value
//  busy              out  1   high from sample latch cycle through output cycle
//  overrun           out  1   sticky: a sample trigger arrived while busy; cleared only by reset
// BEHAVIOUR
//  Reset:
//   - state=0, update_controller=0, busy=0, overrun=0, tick counter=0, pos_prev=0, primed=0, FSM=IDLE.
//   - Reset mid-conversion aborts it; no strobe is produced.
//  Trigger:
//   - trigger = (counter wrap at SAMPLE_PERIOD-1 while enable) OR sample_req.
//   - Both in the same cycle count as one trigger.
//   - enable falling clears the counter. enable rising clears primed.
//  IDLE:
//   - On trigger, latch raw: mode0 position; mode1 position-pos_prev (32-bit modulo, wrap-around intentional);
//     mode2 displacement; mode3 0.
//   - Mode 1 with primed=0 gives raw=0.
//   - On every accepted trigger: pos_prev<=position, primed<=1, busy<=1. FSM goes to CONVERT.
//  Trigger while busy:
//   - Dropped; overrun<=1.
//   - pos_prev is not updated, so the next velocity spans the longer interval.
//  CONVERT (sub-module, start/done):
//   - sign=raw[31]; mag=|raw| as 32-bit unsigned (0x80000000 -> 2^31).
//   - mag==0 -> result 0x00000000, done next cycle.
//   - Otherwise shift left 1 bit/cycle until mag[31]=1; exp = 158 - shifts.
//   - Mantissa = mag[30:8], round-to-nearest-even on mag[7:0].
//   - Mantissa carry-out increments exp and zeroes the mantissa.
//   - Latency trigger->strobe: <= 35 cycles. Never produce NaN/Inf/denormals.
//  OUTPUT:
//   - state<=result, update_controller=1 for exactly one cycle, busy<=0 next cycle, FSM=IDLE.
//   - A trigger in this cycle is an overrun.
//  control_mode changes take effect at the next accepted trigger; the in-flight conversion is unaffected.
// STRUCTURE
//  - pid_pkg:
//    - typedef enum logic[1:0] ctrl_mode_t {CTRL_POSITION, CTRL_VELOCITY, CTRL_DISPLACEMENT, CTRL_RESERVED}
//    - localparams FLOAT_ZERO=32'h0, FLOAT_EXP_BIAS=127, INT32_EXP_MAX=158.
//  - Sub-module int32_to_float_seq: start/raw in, done/result out, own IDLE/NORM/ROUND FSM.
//  - Top holds the tick counter, mode mux, pos_prev/primed, overrun and output registers.
//  - Elaboration assertion: SAMPLE_PERIOD >= 40.
// TESTING
//  1. mode0, position=1000, SAMPLE_PERIOD=64 -> strobe within 35 cycles of wrap, state=0x447A0000.
//  2. mode0, position=-1 -> 0xBF800000; position=0x80000000 -> 0xCF000000; position=0 -> 0x00000000.
//  3. Rounding: position=16777217 -> 0x4B800000 (tie to even); 16777219 -> 0x4B800002;
//     0x7FFFFFFF -> 0x4F000000.
//  4. mode1: first sample -> 0x00000000; then 100 -> 150 gives 0x42480000.
//     Wrap: prev 0x7FFFFFFF, now 0x80000000 -> 0x3F800000.
//  5. sample_req pulsed 5 cycles after a tick -> overrun=1, exactly one strobe, pos_prev unchanged.
//     Only reset clears overrun.
//  6. reset asserted mid-CONVERT -> no strobe, state=0, busy=0 on the next cycle.
//     The first sample after reset in mode1 yields 0.

Source files
------------

// File: rtl/pid_state_sampler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pid_pkg : shared types and constants for the PID state sampler       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pid_pkg;

   typedef enum logic [1:0] {
      CTRL_POSITION     = 2'd0,
      CTRL_VELOCITY     = 2'd1,
      CTRL_DISPLACEMENT = 2'd2,
      CTRL_RESERVED     = 2'd3
   } ctrl_mode_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_OUTPUT  = 2'd2
   } sampler_state_t;

   typedef enum logic [1:0] {
      CONV_IDLE  = 2'd0,
      CONV_NORM  = 2'd1,
      CONV_ROUND = 2'd2
   } conv_state_t;

   localparam logic [31:0] FLOAT_ZERO     = 32'h0000_0000;
   localparam int          FLOAT_EXP_BIAS = 127;
   // Exponent of a value whose leading one sits at bit 31.
   localparam int          INT32_EXP_MAX  = FLOAT_EXP_BIAS + 31;

endpackage
`default_nettype wire

// File: rtl/pid_state_sampler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pid_state_sampler_if : sample inputs and float state outputs          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pid_state_sampler_if;
   logic        enable;
   logic        sample_req;
   logic [1:0]  control_mode;
   logic [31:0] position;
   logic [31:0] displacement;
   logic [31:0] state;
   logic        update_controller;
   logic        busy;
   logic        overrun;

   modport master (
      output enable, sample_req, control_mode, position, displacement,
      input  state, update_controller, busy, overrun
   );

   modport slave (
      input  enable, sample_req, control_mode, position, displacement,
      output state, update_controller, busy, overrun
   );
endinterface
`default_nettype wire

// File: rtl/pid_state_sampler_int32_to_float_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | int32_to_float_seq : serial int32 -> IEEE-754 single, 1 bit/cycle     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module int32_to_float_seq
   import pid_pkg::*;
(
   input  wire logic        clock,
   input  wire logic        reset,
   input  wire logic        start,
   input  wire logic [31:0] raw,
   output logic             done,
   output logic [31:0]      result
);

   conv_state_t r_fsm;
   logic        r_sign;
   logic [31:0] r_mag;
   logic [4:0]  r_shifts;
   logic        r_done;
   logic [31:0] r_result;

   logic        w_round_up;
   logic [23:0] w_mant_sum;
   logic [7:0]  w_exp;

   // Nearest-even: round up on guard with sticky, or on an exact tie with odd lsb.
   assign w_round_up = r_mag[7] & ((|r_mag[6:0]) | r_mag[8]);
   assign w_mant_sum = {1'b0, r_mag[30:8]} + {23'd0, w_round_up};
   assign w_exp      = 8'(INT32_EXP_MAX) - {3'b000, r_shifts} + {7'd0, w_mant_sum[23]};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_fsm    <= CONV_IDLE;
         r_sign   <= 1'b0;
         r_mag    <= '0;
         r_shifts <= '0;
         r_done   <= 1'b0;
         r_result <= FLOAT_ZERO;
      end else begin
         r_done <= 1'b0;
         case (r_fsm)
            CONV_IDLE: begin
               if (start) begin
                  r_sign   <= raw[31];
                  r_mag    <= raw[31] ? (~raw + 32'd1) : raw;
                  r_shifts <= '0;
                  r_fsm    <= CONV_NORM;
               end
            end
            CONV_NORM: begin
               if (r_mag == 32'd0) begin
                  r_result <= FLOAT_ZERO;
                  r_done   <= 1'b1;
                  r_fsm    <= CONV_IDLE;
               end else if (r_mag[31]) begin
                  r_fsm <= CONV_ROUND;
               end else begin
                  r_mag    <= r_mag << 1;
                  r_shifts <= r_shifts + 5'd1;
               end
            end
            CONV_ROUND: begin
               // A mantissa carry-out leaves the low 23 bits at zero already.
               r_result <= {r_sign, w_exp, w_mant_sum[22:0]};
               r_done   <= 1'b1;
               r_fsm    <= CONV_IDLE;
            end
            default: r_fsm <= CONV_IDLE;
         endcase
      end
   end

   assign done   = r_done;
   assign result = r_result;

endmodule
`default_nettype wire

// File: rtl/pid_state_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pid_state_sampler : periodic encoder sampler feeding the float PID   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pid_state_sampler
   import pid_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 50000
) (
   input  wire logic          clock,
   input  wire logic          reset,
   pid_state_sampler_if.slave bus
);

   localparam int                c_tick_w    = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(SAMPLE_PERIOD - 1);

   if (SAMPLE_PERIOD < 40) begin : g_period_check
      $error("pid_state_sampler: SAMPLE_PERIOD must be >= 40");
   end

   sampler_state_t      r_fsm;
   logic [c_tick_w-1:0] r_tick;
   logic                r_enable_d;
   logic [31:0]         r_pos_prev;
   logic                r_primed;
   logic [31:0]         r_state;
   logic                r_update;
   logic                r_busy;
   logic                r_overrun;

   logic        w_tick_wrap;
   logic        w_trigger;
   logic        w_accept;
   logic        w_enable_rise;
   logic        w_primed_eff;
   ctrl_mode_t  w_mode;
   logic [31:0] w_raw;
   logic        w_conv_done;
   logic [31:0] w_conv_result;

   assign w_tick_wrap   = bus.enable && (r_tick == c_tick_last);
   assign w_trigger     = w_tick_wrap || bus.sample_req;
   assign w_accept      = w_trigger && (r_fsm == S_IDLE);
   assign w_enable_rise = bus.enable && !r_enable_d;
   // A sample taken in the same cycle enable rises must already see primed cleared.
   assign w_primed_eff  = r_primed && !w_enable_rise;
   assign w_mode        = ctrl_mode_t'(bus.control_mode);

   always_comb begin
      w_raw = '0;
      case (w_mode)
         CTRL_POSITION:     w_raw = bus.position;
         CTRL_VELOCITY:     w_raw = w_primed_eff ? (bus.position - r_pos_prev) : 32'd0;
         CTRL_DISPLACEMENT: w_raw = bus.displacement;
         default:           w_raw = '0;
      endcase
   end

   int32_to_float_seq u_conv (
      .clock  (clock),
      .reset  (reset),
      .start  (w_accept),
      .raw    (w_raw),
      .done   (w_conv_done),
      .result (w_conv_result)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_fsm      <= S_IDLE;
         r_tick     <= '0;
         r_enable_d <= 1'b0;
         r_pos_prev <= '0;
         r_primed   <= 1'b0;
         r_state    <= FLOAT_ZERO;
         r_update   <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_enable_d <= bus.enable;
         r_update   <= 1'b0;

         if (!bus.enable || w_tick_wrap) r_tick <= '0;
         else                            r_tick <= r_tick + 1'b1;

         if (w_accept) begin
            r_pos_prev <= bus.position;
            r_primed   <= 1'b1;
         end else if (w_enable_rise) begin
            r_primed <= 1'b0;
         end

         // Triggers during a conversion are dropped, keeping pos_prev on the older sample.
         if (w_trigger && (r_fsm != S_IDLE)) r_overrun <= 1'b1;

         case (r_fsm)
            S_IDLE: begin
               if (w_accept) begin
                  r_busy <= 1'b1;
                  r_fsm  <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               if (w_conv_done) begin
                  r_state  <= w_conv_result;
                  r_update <= 1'b1;
                  r_fsm    <= S_OUTPUT;
               end
            end
            S_OUTPUT: begin
               r_busy <= 1'b0;
               r_fsm  <= S_IDLE;
            end
            default: begin
               r_busy <= 1'b0;
               r_fsm  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.state             = r_state;
   assign bus.update_controller = r_update;
   assign bus.busy              = r_busy;
   assign bus.overrun           = r_overrun;

endmodule
`default_nettype wire
